// File: rtl/alu_seq_core.sv
// Sequenced ALU core: operands A and B are loaded on successive btn_load presses, then the op runs.
// Define ACC_CHAIN_EN to add the acc_en port, which feeds the result back as the next A operand.
module alu_seq_core #(
    parameter int  WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ACC_CHAIN_EN
    input  logic             acc_en,
`endif
    input  logic             btn_load,
    input  logic [WIDTH-1:0] sw_data,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_EXEC   = 3'd2,
        S_SHIFT  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2:0]         sh_op_q, sh_op_d;
    logic               btn_q;
    logic               press;

    logic [WIDTH:0]     add_w, sub_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [WIDTH-1:0]   step_val;
    logic               step_out;

    assign press = btn_load & ~btn_q;

    // ADD/SUB at WIDTH+1 bits: the extra bit is carry for ADD and borrow for SUB.
    assign add_w = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'd0: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd1: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            default: ;
        endcase
    end

    // One-bit shift step using the op latched in EXEC, so later op changes cannot disturb it.
    always_comb begin
        case (sh_op_q)
            3'd5: begin
                step_val = {sh_q[WIDTH-2:0], 1'b0};
                step_out = sh_q[WIDTH-1];
            end
            3'd6: begin
                step_val = {1'b0, sh_q[WIDTH-1:1]};
                step_out = sh_q[0];
            end
            default: begin
                step_val = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                step_out = sh_q[0];
            end
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no path infers a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        sh_op_d  = sh_op_q;
        case (state_q)
            S_LOAD_A: if (press) begin
                a_d     = sw_data;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: if (press) begin
                b_d     = sw_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op < 3'd5) begin
                    result_d = alu_res;
                    carry_d  = alu_c;
                    ovf_d    = alu_v;
                    state_d  = S_DONE;
                end else if (shamt == '0) begin
                    result_d = a_q;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    sh_d    = a_q;
                    cnt_d   = shamt;
                    sh_op_d = op;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_d  = step_val;
                cnt_d = cnt_q - SHW'(1);
                // Flags are committed only with the final result, so they hold the previous op until then.
                if (cnt_q == SHW'(1)) begin
                    result_d = step_val;
                    carry_d  = step_out;
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_LOAD_A;
`ifdef ACC_CHAIN_EN
                if (acc_en) begin
                    a_d     = result_q;
                    state_d = S_LOAD_B;
                end
`endif
            end
            default: state_d = S_LOAD_A;
        endcase
        zero_d = (result_d == '0);
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
            sh_op_q  <= '0;
            btn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            sh_op_q  <= sh_op_d;
            btn_q    <= btn_load;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == S_EXEC) || (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core at WIDTH=8; expected results are queued at the B press
// and popped when done pulses. The acc_en scenario is included when ACC_CHAIN_EN is defined.
module tb_alu_seq_core;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             acc_en;
    logic             btn_load;
    logic [WIDTH-1:0] sw_data;
    logic [2:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             zero, carry, overflow, busy, done;
    logic [2:0]       state_o;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             c;
        logic             v;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    alu_seq_core #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef ACC_CHAIN_EN
        .acc_en   (acc_en),
`endif
        .btn_load (btn_load),
        .sw_data  (sw_data),
        .op       (op),
        .shamt    (shamt),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] o, input int s);
        exp_t             e;
        int               sa, sbv, r;
        logic signed [7:0] t;
        sa  = $signed(a);
        sbv = $signed(b);
        e   = '0;
        case (o)
            3'd0: begin
                r     = int'(a) + int'(b);
                e.res = r[7:0];
                e.c   = (r > 255);
                e.v   = (sa + sbv > 127) || (sa + sbv < -128);
            end
            3'd1: begin
                e.res = a - b;
                e.c   = (a < b);
                e.v   = (sa - sbv > 127) || (sa - sbv < -128);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: begin
                e.res = a << s;
                e.c   = (s > 0) ? a[8 - s] : 1'b0;
            end
            3'd6: begin
                e.res = a >> s;
                e.c   = (s > 0) ? a[s - 1] : 1'b0;
            end
            default: begin
                t     = a;
                e.res = t >>> s;
                e.c   = (s > 0) ? a[s - 1] : 1'b0;
            end
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    task automatic press(input logic [7:0] v);
        @(negedge clk);
        sw_data  = v;
        btn_load = 1'b1;
        @(negedge clk);
        btn_load = 1'b0;
    endtask

    // Runs one op; disturb toggles btn_load/sw_data every cycle and scrambles op/shamt once in SHIFT.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                          input int s, input bit load_a, input bit disturb);
        exp_t e;
        int   cycles, busy_cnt, exp_lat;
        logic [2:0] exp_next;
        if (load_a) press(a);
        op    = o;
        shamt = SHW'(s);
        press(b);
        sb.push_back(model(a, b, o, s));
        exp_lat  = (o >= 3'd5 && s > 0) ? 2 + s : 2;
        cycles   = 1;
        busy_cnt = 0;
        while (!done && cycles < 60) begin
            if (busy) busy_cnt++;
            if (disturb) begin
                btn_load = ~btn_load;
                sw_data  = 8'($urandom);
                if (cycles >= 2) begin
                    op    = 3'($urandom);
                    shamt = SHW'($urandom);
                end
            end
            @(negedge clk);
            cycles++;
        end
        btn_load = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout op=%0d: done=%b after %0d cycles, required 1", o, done, cycles);
        end
        vectors++;
        if (cycles !== exp_lat) begin
            miscompares++;
            $display("FAIL latency op=%0d shamt=%0d: got %0d cycles, required %0d", o, s, cycles, exp_lat);
        end
        vectors++;
        if (busy_cnt !== exp_lat - 1) begin
            miscompares++;
            $display("FAIL busy_cycles op=%0d: got %0d, required %0d", o, busy_cnt, exp_lat - 1);
        end
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty op=%0d: no expected entry, required 1", o);
        end else begin
            e = sb.pop_front();
            vectors++;
            if ({result, zero, carry, overflow} !== {e.res, e.z, e.c, e.v}) begin
                miscompares++;
                $display("FAIL result op=%0d a=%h b=%h s=%0d: got res=%h z=%b c=%b v=%b, required res=%h z=%b c=%b v=%b",
                         o, a, b, s, result, zero, carry, overflow, e.res, e.z, e.c, e.v);
            end
        end
        exp_next = acc_en ? 3'd1 : 3'd0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || state_o !== exp_next) begin
            miscompares++;
            $display("FAIL after_done op=%0d: done=%b state=%0d, required done=0 state=%0d",
                     o, done, state_o, exp_next);
        end
        vectors++;
        if (result !== e.res) begin
            miscompares++;
            $display("FAIL result_hold op=%0d: got %h, required %h", o, result, e.res);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        btn_load = 1'b0;
        sw_data  = '0;
        op       = '0;
        shamt    = '0;
        acc_en   = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({result, zero, carry, overflow, busy, done, state_o} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL reset: got res=%h z=%b c=%b v=%b busy=%b done=%b st=%0d, required res=00 z=1 c=0 v=0 busy=0 done=0 st=0",
                     result, zero, carry, overflow, busy, done, state_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        run_op(8'h7F, 8'h01, 3'd0, 0, 1'b1, 1'b0);
        run_op(8'h00, 8'h01, 3'd1, 0, 1'b1, 1'b0);
        run_op(8'hF0, 8'h0F, 3'd2, 0, 1'b1, 1'b0);
        run_op(8'hF0, 8'h0C, 3'd3, 0, 1'b1, 1'b0);
        run_op(8'hAA, 8'hFF, 3'd4, 0, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 3'd0, 0, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 3'd1, 0, 1'b1, 1'b0);
        run_op(8'h55, 8'h55, 3'd1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_shift();
        run_op(8'h81, 8'h00, 3'd6, 3, 1'b1, 1'b0);
        run_op(8'h80, 8'h00, 3'd7, 7, 1'b1, 1'b0);
        run_op(8'h81, 8'h00, 3'd5, 1, 1'b1, 1'b0);
        run_op(8'h81, 8'h00, 3'd5, 0, 1'b1, 1'b0);
        run_op(8'hF0, 8'h00, 3'd7, 0, 1'b1, 1'b0);
        run_op(8'h01, 8'h00, 3'd6, 7, 1'b1, 1'b0);
        run_op(8'h40, 8'h00, 3'd5, 2, 1'b1, 1'b0);
        run_op(8'hB6, 8'h00, 3'd7, 4, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_presses();
        run_op(8'hC3, 8'h5A, 3'd6, 5, 1'b1, 1'b1);
        run_op(8'h96, 8'h33, 3'd0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_held_button();
        @(negedge clk);
        sw_data  = 8'h11;
        btn_load = 1'b1;
        repeat (5) @(negedge clk);
        btn_load = 1'b0;
        vectors++;
        if (state_o !== 3'd1) begin
            miscompares++;
            $display("FAIL held_button: state=%0d, required 1", state_o);
        end
        run_op(8'h11, 8'h22, 3'd0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_shift();
        press(8'h81);
        op    = 3'd5;
        shamt = 3'd7;
        press(8'h00);
        repeat (2) @(negedge clk);
        vectors++;
        if (state_o !== 3'd3) begin
            miscompares++;
            $display("FAIL mid_shift_state: state=%0d, required 3", state_o);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({result, zero, carry, overflow, busy, done, state_o} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_mid_shift: got res=%h z=%b c=%b v=%b busy=%b done=%b st=%0d, required res=00 z=1 c=0 v=0 busy=0 done=0 st=0",
                     result, zero, carry, overflow, busy, done, state_o);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h12, 8'h34, 3'd0, 0, 1'b1, 1'b0);
    endtask

`ifdef ACC_CHAIN_EN
    task automatic test_acc_chain();
        acc_en = 1'b1;
        run_op(8'h05, 8'h03, 3'd0, 0, 1'b1, 1'b0);
        acc_en = 1'b0;
        run_op(8'h08, 8'h02, 3'd0, 0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_ignored_presses();
        test_held_button();
        test_back_to_back();
        test_reset_mid_shift();
`ifdef ACC_CHAIN_EN
        test_acc_chain();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
